// File: rtl/medidor_dpwm.sv
// PWM receive-side meter: high time, period and 4-bit duty code.
// Single clock, synchronous active-high reset.
module medidor_dpwm #(
   parameter int CNT_W = 20
) (
   input  logic             CLK_100MHz,
   input  logic             reset,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] alto,
   output logic [CNT_W-1:0] periodo,
   output logic [3:0]       cuenta_CT,
   output logic             medida_lista,
   output logic             medida_valida,
   output logic             sin_senal
);

   typedef enum logic [1:0] {
      ESPERA,
      ALTO,
      BAJO
   } estado_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_UNO = CNT_W'(1);
   localparam logic [CNT_W-1:0] P_MIN   = CNT_W'(5);

   logic [2:0]       sinc_q;
   logic             sube_q;
   logic             baja_q;
   estado_t          estado_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] h_q;
   logic [CNT_W-1:0] div_h_q;
   logic [CNT_W-1:0] div_p_q;
   logic [CNT_W:0]   rem_q;
   logic [3:0]       coc_q;
   logic [1:0]       it_q;
   logic             busy_q;
   logic [CNT_W-1:0] alto_q;
   logic [CNT_W-1:0] periodo_q;
   logic [3:0]       ct_q;
   logic             lista_q;
   logic             valida_q;
   logic             sin_q;

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W:0]   rem_sh;
   logic [CNT_W:0]   rem_d;
   logic             q_bit;
   logic [3:0]       coc_d;
   logic             div_libre;

   // Metastability guard only; left unreset so a level already high
   // at reset release does not look like a fresh rising edge.
   always_ff @(posedge CLK_100MHz) begin
      sinc_q <= {sinc_q[1:0], pwm_in};
   end

   always_ff @(posedge CLK_100MHz) begin
      if (reset) begin
         sube_q <= 1'b0;
         baja_q <= 1'b0;
      end else begin
         sube_q <= sinc_q[1] & ~sinc_q[2];
         baja_q <= ~sinc_q[1] & sinc_q[2];
      end
   end

   always_comb begin
      cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_UNO;
      rem_sh = rem_q << 1;
      q_bit  = rem_sh >= {1'b0, div_p_q};
      rem_d  = q_bit ? rem_sh - {1'b0, div_p_q} : rem_sh;
      coc_d  = {coc_q[2:0], q_bit};
      // The output cycle still counts as busy: it sets the 6-cycle floor.
      div_libre = ~busy_q & ~lista_q;
   end

   always_ff @(posedge CLK_100MHz) begin
      if (reset) begin
         estado_q  <= ESPERA;
         cnt_q     <= '0;
         h_q       <= '0;
         div_h_q   <= '0;
         div_p_q   <= '0;
         rem_q     <= '0;
         coc_q     <= '0;
         it_q      <= '0;
         busy_q    <= 1'b0;
         alto_q    <= '0;
         periodo_q <= '0;
         ct_q      <= '0;
         lista_q   <= 1'b0;
         valida_q  <= 1'b0;
         sin_q     <= 1'b1;
      end else begin
         lista_q <= 1'b0;
         if (busy_q) begin
            rem_q <= rem_d;
            coc_q <= coc_d;
            it_q  <= it_q + 2'd1;
            if (it_q == 2'd3) begin
               busy_q    <= 1'b0;
               alto_q    <= div_h_q;
               periodo_q <= div_p_q;
               ct_q      <= coc_d;
               lista_q   <= 1'b1;
               valida_q  <= 1'b1;
               sin_q     <= 1'b0;
            end
         end
         unique case (estado_q)
            ESPERA: begin
               if (sube_q) begin
                  estado_q <= ALTO;
                  cnt_q    <= CNT_UNO;
               end
            end
            ALTO: begin
               if (baja_q) begin
                  h_q      <= cnt_q;
                  cnt_q    <= cnt_d;
                  estado_q <= BAJO;
               end else if (cnt_q == CNT_MAX) begin
                  estado_q <= ESPERA;
                  sin_q    <= 1'b1;
                  valida_q <= 1'b0;
                  ct_q     <= 4'd15;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            BAJO: begin
               if (sube_q) begin
                  if (div_libre && cnt_q > P_MIN) begin
                     div_h_q <= h_q;
                     div_p_q <= cnt_q;
                     rem_q   <= {1'b0, h_q};
                     coc_q   <= '0;
                     it_q    <= '0;
                     busy_q  <= 1'b1;
                  end
                  cnt_q    <= CNT_UNO;
                  estado_q <= ALTO;
               end else if (cnt_q == CNT_MAX) begin
                  estado_q <= ESPERA;
                  sin_q    <= 1'b1;
                  valida_q <= 1'b0;
                  ct_q     <= 4'd0;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: estado_q <= ESPERA;
         endcase
      end
   end

   assign alto          = alto_q;
   assign periodo       = periodo_q;
   assign cuenta_CT     = ct_q;
   assign medida_lista  = lista_q;
   assign medida_valida = valida_q;
   assign sin_senal     = sin_q;

endmodule

// File: tb/tb_medidor_dpwm.sv
// Directed bench for medidor_dpwm with an 8-bit counter (timeout 255).
// PWM generator runs in the background; checks sample on the falling edge.
module tb_medidor_dpwm;

   localparam int W = 8;

   logic         clk;
   logic         reset;
   logic         pwm_in;
   logic [W-1:0] alto;
   logic [W-1:0] periodo;
   logic [3:0]   cuenta_CT;
   logic         medida_lista;
   logic         medida_valida;
   logic         sin_senal;

   medidor_dpwm #(.CNT_W(W)) dut (
      .CLK_100MHz   (clk),
      .reset        (reset),
      .pwm_in       (pwm_in),
      .alto         (alto),
      .periodo      (periodo),
      .cuenta_CT    (cuenta_CT),
      .medida_lista (medida_lista),
      .medida_valida(medida_valida),
      .sin_senal    (sin_senal)
   );

   typedef struct {
      int hi;
      int lo;
      int ea;
      int ep;
      int ect;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int hi_t = 30;
   int lo_t = 70;
   int mode = 0;
   int rise_cyc = 0;
   int n_lista = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (medida_lista) n_lista <= n_lista + 1;

   // mode 0: held low, 1: PWM hi_t/lo_t, 2: held high
   initial begin
      pwm_in = 1'b0;
      forever begin
         if (mode == 0) begin
            @(negedge clk);
            pwm_in = 1'b0;
         end else if (mode == 2) begin
            @(negedge clk);
            if (!pwm_in) rise_cyc = cyc;
            pwm_in = 1'b1;
         end else begin
            @(negedge clk);
            if (!pwm_in) rise_cyc = cyc;
            pwm_in = 1'b1;
            repeat (hi_t) @(negedge clk);
            pwm_in = 1'b0;
            repeat (lo_t - 1) @(negedge clk);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic wait_lista(input int bound, input string nm);
      bit got = 1'b0;
      for (int i = 0; i < bound && !got; i++) begin
         @(negedge clk);
         if (medida_lista) got = 1'b1;
      end
      chk({nm, " lista seen"}, int'(got), 1);
   endtask

   task automatic wait_sin(input int bound, input string nm);
      bit got = 1'b0;
      for (int i = 0; i < bound && !got; i++) begin
         @(negedge clk);
         if (sin_senal) got = 1'b1;
      end
      chk({nm, " sin_senal seen"}, int'(got), 1);
   endtask

   task automatic chk_meas(input string nm, input int a, input int p,
                           input int ct);
      chk({nm, " alto"}, int'(alto), a);
      chk({nm, " periodo"}, int'(periodo), p);
      chk({nm, " cuenta_CT"}, int'(cuenta_CT), ct);
   endtask

   task automatic chk_reset(input string nm);
      chk_meas(nm, 0, 0, 0);
      chk({nm, " lista"}, int'(medida_lista), 0);
      chk({nm, " valida"}, int'(medida_valida), 0);
      chk({nm, " sin"}, int'(sin_senal), 1);
   endtask

   vec_t tbl[5];
   int base;
   int rel;

   initial begin
      tbl[0] = '{hi: 99, lo: 1,  ea: 99, ep: 100, ect: 15};
      tbl[1] = '{hi: 1,  lo: 99, ea: 1,  ep: 100, ect: 0};
      tbl[2] = '{hi: 50, lo: 50, ea: 50, ep: 100, ect: 8};
      tbl[3] = '{hi: 3,  lo: 3,  ea: 3,  ep: 6,   ect: 8};
      tbl[4] = '{hi: 40, lo: 60, ea: 40, ep: 100, ect: 6};

      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      reset = 1'b0;

      // 30/70 steady PWM and latency from the closing edge
      hi_t = 30;
      lo_t = 70;
      mode = 1;
      wait_lista(400, "p30");
      chk("latency", cyc - rise_cyc, 8);
      chk_meas("p30", 30, 100, 4);
      chk("p30 valida", int'(medida_valida), 1);
      chk("p30 sin", int'(sin_senal), 0);
      base = n_lista;
      repeat (500) @(negedge clk);
      chk("p30 pulses/500", n_lista - base, 5);

      foreach (tbl[k]) begin
         hi_t = tbl[k].hi;
         lo_t = tbl[k].lo;
         repeat (3) wait_lista(400, $sformatf("vec%0d", k));
         chk_meas($sformatf("vec%0d", k), tbl[k].ea, tbl[k].ep,
                  tbl[k].ect);
      end

      // periods of 4 and 5 are never reported
      for (int lo = 2; lo <= 3; lo++) begin
         hi_t = 2;
         lo_t = lo;
         repeat (150) @(negedge clk);
         base = n_lista;
         repeat (100) @(negedge clk);
         chk($sformatf("overrun p%0d", 2 + lo), n_lista - base, 0);
      end

      // stuck high after a valid measurement
      hi_t = 30;
      lo_t = 70;
      repeat (3) wait_lista(400, "pre-high");
      chk("pre-high valida", int'(medida_valida), 1);
      mode = 2;
      wait_sin(600, "stuck high");
      chk("timeout delay", cyc - rise_cyc, 259);
      chk_meas("stuck high", 30, 100, 15);
      chk("stuck high valida", int'(medida_valida), 0);

      // stuck low
      mode = 1;
      wait_lista(400, "resume");
      chk("resume sin", int'(sin_senal), 0);
      mode = 0;
      wait_sin(600, "stuck low");
      chk("stuck low ct", int'(cuenta_CT), 0);
      chk("stuck low valida", int'(medida_valida), 0);

      // resume with 40/60
      hi_t = 40;
      lo_t = 60;
      mode = 1;
      wait_lista(400, "p40");
      chk_meas("p40", 40, 100, 6);
      chk("p40 valida", int'(medida_valida), 1);
      chk("p40 sin", int'(sin_senal), 0);

      // reset in the middle of the high phase
      hi_t = 30;
      lo_t = 70;
      repeat (2) wait_lista(400, "pre-rst");
      repeat (5) @(negedge clk);
      chk("pre-rst level", int'(pwm_in), 1);
      reset = 1'b1;
      @(negedge clk);
      chk_reset("mid rst");
      reset = 1'b0;
      rel = cyc;
      wait_lista(400, "post-rst");
      chk("post-rst discard", int'((cyc - rel) > 150), 1);
      chk_meas("post-rst", 30, 100, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
